// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit.
//   CLK, RESET     : clock (rising edge) and asynchronous active-high reset
//   Start, Op      : request a new operation; Op 00 smul, 01 umul, 10 sdiv, 11 udiv
//   Operand1/2     : multiplicand/dividend and multiplier/divisor
//   Result1/2      : product low/high half, or quotient/remainder
//   Busy, Done     : high while computing; one-cycle completion pulse
// The operation takes WIDTH cycles. Each cycle does one shift-add step for a
// multiply or one restoring step for a divide. Both kinds of step work on
// operand magnitudes. The sign fix-up is applied on the last step, as the
// result registers load.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH);

  if ((WIDTH % 2 != 0) || (WIDTH < 8) || (WIDTH > 64)) begin : g_bad_width
    $error("muldiv_unit: WIDTH must be even and in 8..64");
  end

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res1_q, res1_d, res2_q, res2_d;

  // Intermediate values for one iteration step.
  logic             sgn, is_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  always_comb begin
    sgn     = ~op_q[0];
    is_div  = op_q[1];
    mag_a   = mag(a_q, sgn);
    mag_b   = mag(b_q, sgn);

    // Multiply: {hi,lo} holds the partial product above the unconsumed multiplier bits.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a} : '0);
    // Divide: hi is the partial remainder and lo shifts the dividend out / the quotient in.
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, mag_b};
    rem_sub = rem_sh[WIDTH-1:0] - mag_b;

    step_hi = is_div ? (rem_ge ? rem_sub : rem_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
    step_lo = is_div ? {lo_q[WIDTH-2:0], rem_ge} : {mul_sum[0], lo_q[WIDTH-1:1]};

    prod = {step_hi, step_lo};
    if (sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) prod = -prod;
    quo = step_lo;
    if (sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) quo = -quo;
    rem = step_hi;
    if (sgn && a_q[WIDTH-1]) rem = -rem;
    // A zero divisor is overridden with all-ones quotient and dividend remainder.
    // Most-negative / -1 needs no special case: the magnitude divide gives 2^(W-1),
    // and negating that value leaves it unchanged.
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res1_d  = res1_q;
    res2_d  = res2_q;

    case (state_q)
      COMPUTING: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          res1_d  = is_div ? quo : prod[WIDTH-1:0];
          res2_d  = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        end
      end
      default: begin
        if (Start) begin
          state_d = COMPUTING;
          op_d    = Op;
          a_d     = Operand1;
          b_d     = Operand2;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = Op[1] ? mag(Operand1, ~Op[0]) : mag(Operand2, ~Op[0]);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

  assign Result1 = res1_q;
  assign Result2 = res2_q;
  assign Busy    = (state_q == COMPUTING);
  assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit at WIDTH=32.
// The stimulus process pushes the expected results and the issue cycle.
// The monitor process checks values, latency and Busy length on each Done.
module tb_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] Operand1 = '0;
  logic [W-1:0] Operand2 = '0;
  logic [W-1:0] Result1, Result2;
  logic         Busy, Done;

  always #5 CLK = ~CLK;

  muldiv_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .Op(Op),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned busy_run = 0;
  logic [2*W-1:0] exp_q[$];
  int unsigned    iss_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: returns {Result2, Result1}.
  function automatic logic [2*W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [W-1:0]    q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      default: begin
        if (b == '0) return {a, {W{1'b1}}};
        // 64-bit signed division truncates toward zero.
        // -2^31 / -1 gives +2^31, which truncates to 0x80000000.
        if (op == 2'b10) begin
          q = W'(sa / sb);
          r = W'(sa % sb);
        end else begin
          q = W'(ua / ub);
          r = W'(ua % ub);
        end
        return {r, q};
      end
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge CLK) begin
    logic [2*W-1:0] e;
    int unsigned    t;
    if (Busy) busy_run++;
    if (Done) begin
      total++;
      if (Busy) begin
        bad++;
        $display("FAIL busy_with_done: Busy=%b Done=%b want Busy=0", Busy, Done);
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got Done=1 want no Done (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        t = iss_q.pop_front();
        chk("result", {Result2, Result1}, e);
        chk("latency", 64'(cyc - t), 64'(LAT));
        chk("busy_len", 64'(busy_run), 64'(W));
      end
      busy_run = 0;
    end
  end

  // Caller must be at a negedge. Leaves the caller at the next negedge.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1;
    Op = op;
    Operand1 = a;
    Operand2 = b;
    exp_q.push_back(ref_model(op, a, b));
    iss_q.push_back(cyc);
    @(negedge CLK);
    Start = 1'b0;
    Op = 2'($urandom);
    Operand1 = $urandom;
    Operand2 = $urandom;
  endtask

  // Advances to the first negedge at which Busy is low (the Done cycle when busy).
  task automatic wait_free();
    int n = 0;
    @(negedge CLK);
    while (Busy && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (Busy) begin
      total++;
      bad++;
      $display("FAIL wait_timeout: Busy=%b want 0 within 100 cycles", Busy);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2*W-1:0] e;
    int n;

    // Check the state while reset is held.
    #1;
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_r1", 64'(Result1), 64'(0));
    chk("rst_r2", 64'(Result2), 64'(0));
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Directed cases (-3 x 5, 0xFFFFFFFF x 0xFFFFFFFF, -7 / 2)
    do_op(2'b00, -32'sd3, 32'd5);
    chk("smul_direct", ref_model(2'b00, -32'sd3, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    wait_free();
    @(negedge CLK);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_free();
    @(negedge CLK);
    do_op(2'b10, -32'sd7, 32'd2);
    wait_free();
    // Back-to-back issue in the Done cycle.
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_free();
    @(negedge CLK);
    do_op(2'b11, 32'd100, 32'd0);
    wait_free();
    @(negedge CLK);
    do_op(2'b10, -32'sd5, 32'd0);
    wait_free();
    @(negedge CLK);

    // Start during COMPUTING is ignored; the results then hold while idle.
    e = ref_model(2'b00, 32'd123456, -32'sd789);
    do_op(2'b00, 32'd123456, -32'sd789);
    repeat (9) @(negedge CLK);
    Start = 1'b1;
    Op = 2'b11;
    Operand1 = 32'd999;
    Operand2 = 32'd7;
    @(negedge CLK);
    Start = 1'b0;
    wait_free();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("hold", {Result2, Result1}, e);
    end

    // Asynchronous reset at cycle 15 of COMPUTING. Start is held high
    // through reset and must be accepted only after RESET falls.
    do_op(2'b01, $urandom, $urandom);
    repeat (14) @(negedge CLK);
    #3;
    RESET = 1'b1;
    exp_q.delete();
    iss_q.delete();
    busy_run = 0;
    #1;
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_done", 64'(Done), 64'(0));
    chk("abort_r1", 64'(Result1), 64'(0));
    chk("abort_r2", 64'(Result2), 64'(0));
    Start = 1'b1;
    Op = 2'b01;
    Operand1 = 32'd6;
    Operand2 = 32'd7;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_hold_busy", 64'(Busy), 64'(0));
    exp_q.push_back(64'd42);
    iss_q.push_back(cyc);
    RESET = 1'b0;
    @(negedge CLK);
    Start = 1'b0;
    chk("post_rst_accept", 64'(Busy), 64'(1));
    wait_free();
    @(negedge CLK);

    // Randomized operations, a mix of back-to-back and spaced issues.
    for (int k = 0; k < 40; k++) begin
      do_op(2'($urandom_range(0, 3)), pick(), pick());
      wait_free();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    chk("drain", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
